// File: rtl/nma_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// master drives operands and carry-in, slave returns sum and carry-out.
interface nma_adder_if #(
  parameter int N = 8
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ci;
  logic [N-1:0] S;
  logic         co;

  modport master (
    output A, B, ci,
    input  S, co
  );

  modport slave (
    input  A, B, ci,
    output S, co
  );
endinterface

// File: rtl/nma_adder.sv
// N-bit ripple-carry adder built from full-adder cells,
// with {co,S} captured on the rising clock edge.
module nma_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module nma_adder #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  nma_adder_if.slave bus
);
  logic [N:0]   carry;
  logic [N-1:0] sum;

  assign carry[0] = bus.ci;

  for (genvar i = 0; i < N; i++) begin : g_cell
    nma_fa u_fa (
      .a  (bus.A[i]),
      .b  (bus.B[i]),
      .c  (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  // Result register; reset wins over the freshly settled sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.S  <= '0;
      bus.co <= 1'b0;
    end else begin
      bus.S  <= sum;
      bus.co <= carry[N];
    end
  end
endmodule

// File: tb/tb_nma_adder.sv
// Bench for nma_adder at widths 1, 4, 8 and 16 driven in lockstep,
// with expected {co,S} queued at drive time and checked after the edge.
module tb_nma_adder;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  nma_adder_if #(.N(1))  b1 ();
  nma_adder_if #(.N(4))  b4 ();
  nma_adder_if #(.N(8))  b8 ();
  nma_adder_if #(.N(16)) b16 ();

  nma_adder #(.N(1))  d1  (.clk(clk), .rst(rst), .bus(b1));
  nma_adder #(.N(4))  d4  (.clk(clk), .rst(rst), .bus(b4));
  nma_adder #(.N(8))  d8  (.clk(clk), .rst(rst), .bus(b8));
  nma_adder #(.N(16)) d16 (.clk(clk), .rst(rst), .bus(b16));

  logic [16:0] q1[$];
  logic [16:0] q4[$];
  logic [16:0] q8[$];
  logic [16:0] q16[$];

  int vec = 0;
  int bad = 0;

  function automatic logic [16:0] model(
    input int          w,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c,
    input logic        r
  );
    logic [16:0] m;
    m = (17'd1 << w) - 17'd1;
    if (r) return 17'd0;
    return ({1'b0, a} & m) + ({1'b0, b} & m) + {16'd0, c};
  endfunction

  task automatic chk(
    input string       tag,
    input string       w,
    input logic [16:0] obs,
    input logic [16:0] exp
  );
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s got %h want %h", tag, w, obs, exp);
    end
  endtask

  task automatic apply(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c,
    input logic        r
  );
    rst    = r;
    b1.A   = a[0];
    b1.B   = b[0];
    b1.ci  = c;
    b4.A   = a[3:0];
    b4.B   = b[3:0];
    b4.ci  = c;
    b8.A   = a[7:0];
    b8.B   = b[7:0];
    b8.ci  = c;
    b16.A  = a;
    b16.B  = b;
    b16.ci = c;
    q1.push_back(model(1, a, b, c, r));
    q4.push_back(model(4, a, b, c, r));
    q8.push_back(model(8, a, b, c, r));
    q16.push_back(model(16, a, b, c, r));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    chk(tag, "n1", {15'd0, b1.co, b1.S}, q1.pop_front());
    chk(tag, "n4", {12'd0, b4.co, b4.S}, q4.pop_front());
    chk(tag, "n8", {8'd0, b8.co, b8.S}, q8.pop_front());
    chk(tag, "n16", {b16.co, b16.S}, q16.pop_front());
  endtask

  task automatic step(
    input string       tag,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c,
    input logic        r
  );
    apply(a, b, c, r);
    tick(tag);
  endtask

  // Directed checks, then randomised vectors with sporadic reset.
  initial begin
    step("rst0", 16'h5A5A, 16'h3333, 1'b1, 1'b1);
    step("rst1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step("rel", 16'h0012, 16'h0034, 1'b0, 1'b0);
    step("zero", 16'h0000, 16'h0000, 1'b0, 1'b0);
    step("ff00", 16'h00FF, 16'h0000, 1'b0, 1'b0);
    step("ff01", 16'h00FF, 16'h0001, 1'b0, 1'b0);
    step("ff00b", 16'h00FF, 16'h0000, 1'b0, 1'b0);
    step("ff81", 16'h00FF, 16'h0081, 1'b0, 1'b0);
    step("ff91", 16'h00FF, 16'h0091, 1'b0, 1'b0);
    step("ef91", 16'h00EF, 16'h0091, 1'b0, 1'b0);
    step("efd1", 16'h00EF, 16'h00D1, 1'b0, 1'b0);
    step("afd1", 16'h00AF, 16'h00D1, 1'b0, 1'b0);
    step("2fd1", 16'h002F, 16'h00D1, 1'b0, 1'b0);
    step("2f51", 16'h002F, 16'h0051, 1'b0, 1'b0);
    step("ciff", 16'h00FF, 16'h00FF, 1'b1, 1'b0);
    step("ci00", 16'h0000, 16'h0000, 1'b1, 1'b0);
    step("maxw", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    step("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    step("midr", 16'h1234, 16'h4321, 1'b1, 1'b1);
    step("post", 16'h1234, 16'h4321, 1'b1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic        rr;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rr = ($urandom_range(0, 15) == 0);
      step("rand", ra, rb, rc, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
